// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with byte/half/word loads and stores
// ports: clk; rst_n async active-low; req_valid/req_ready request handshake carrying mem_read, mem_write,
//        funct3, addr, wdata; rsp_valid/rsp_ready response handshake carrying rdata, rsp_err
module dmem_responder #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t st, st_nxt;
  logic rd, wr, err, half, word;
  logic [2:0] f3;
  logic [31:0] a, wd, word_q, sh, ld, merged;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = st == IDLE;
  assign rsp_valid = st == RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;
  always_comb
    st_nxt = st == IDLE ? (req_valid ? BUSY : IDLE) : st == BUSY ? RESP : (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= 1'b0;
      wr <= 1'b0;
      f3 <= 3'd0;
      a  <= 32'd0;
      wd <= 32'd0;
    end else if (st == IDLE && req_valid) begin
      rd <= mem_read;
      wr <= mem_write;
      f3 <= funct3;
      a  <= addr;
      wd <= wdata;
    end
  // funct3[1:0] encodes size for both loads and stores; funct3[2] selects zero-extension
  always_comb begin
    half   = f3[1:0] == 2'd1;
    word   = f3[1:0] == 2'd2;
    err    = (rd == wr) | (rd & (f3 == 3'd3 | f3[2:1] == 2'b11)) | (wr & f3 > 3'd2)
           | (half & a[0]) | (word & a[1:0] != 2'b00) | ({1'b0, a} >= LIMIT);
    idx    = a[AW+1:2];
    word_q = mem[idx];
    sh     = word_q >> {a[1:0], 3'b000};
    ld     = word ? word_q : half ? {{16{sh[15] & ~f3[2]}}, sh[15:0]} : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
    be     = word ? 4'hf : half ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a[1:0];
    merged = wd << {a[1:0], 3'b000};
  end
  // async reset keeps st out of BUSY, so a store interrupted by reset never commits
  always_ff @(posedge clk)
    if (st == BUSY && wr && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= merged[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata   <= 32'd0;
      rsp_err <= 1'b0;
    end else if (st == BUSY) begin
      rdata   <= (err | wr) ? 32'd0 : ld;
      rsp_err <= err;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against a byte-array model
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  int checks = 0, errors = 0;
  logic [7:0] mm [1024];
  logic [31:0] exp_rdata = 32'd0;
  logic exp_err = 1'b0;
  bit pend = 1'b0;
  logic [31:0] g;
  logic ge;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata), .rsp_err(rsp_err)
  );

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", n, got, want, $time);
    end
  endfunction

  // reference behaviour: byte-addressed memory, size from funct3, extension by plain arithmetic
  function automatic void model(input logic r, input logic w, input logic [2:0] f, input logic [31:0] ad,
                                input logic [31:0] d, output logic [31:0] rv, output logic e);
    int n;
    n  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e  = (r == w) || (r && (f == 3 || f >= 6)) || (w && f > 2) || (ad % 32'(n) != 0) || (ad >= 32'd1024);
    rv = 32'd0;
    if (!e && w)
      for (int i = 0; i < n; i++) mm[int'(ad) + i] = d[8*i +: 8];
    if (!e && r) begin
      for (int i = 0; i < n; i++) rv[8*i +: 8] = mm[int'(ad) + i];
      if (!f[2] && n < 4 && rv[8*n-1]) rv = rv | ~((32'd1 << (8*n)) - 32'd1);
    end
  endfunction

  always @(negedge clk)
    if (rst_n && pend && rsp_valid) begin
      chk("resp_rdata", rdata, exp_rdata);
      chk("resp_err", 32'(rsp_err), 32'(exp_err));
      chk("resp_req_ready", 32'(req_ready), 0);
    end

  task automatic chk_reset_outputs(input string n);
    chk({n, "_req_ready"}, 32'(req_ready), 1);
    chk({n, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({n, "_rdata"}, rdata, 0);
    chk({n, "_rsp_err"}, 32'(rsp_err), 0);
  endtask

  task automatic issue(input logic r, input logic w, input logic [2:0] f, input logic [31:0] ad,
                       input logic [31:0] d, input bit use_model);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req_ready=0 expected=1 at %0t", $time);
    end
    mem_read = r; mem_write = w; funct3 = f; addr = ad; wdata = d; req_valid = 1'b1;
    if (use_model) model(r, w, f, ad, d, exp_rdata, exp_err);
    @(posedge clk);
    #1;
    req_valid = 1'($urandom_range(0, 1));
    mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom_range(0, 1023); wdata = $urandom;
  endtask

  task automatic xact(input logic r, input logic w, input logic [2:0] f, input logic [31:0] ad,
                      input logic [31:0] d, input int hold, output logic [31:0] got, output logic got_e);
    int n = 0;
    got = 32'hx;
    got_e = 1'bx;
    issue(r, w, f, ad, d, 1);
    @(negedge clk);
    chk("busy_rsp_valid", 32'(rsp_valid), 0);
    chk("busy_req_ready", 32'(req_ready), 0);
    pend = 1'b1;
    @(negedge clk);
    chk("latency_rsp_valid", 32'(rsp_valid), 1);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      pend = 1'b0;
      req_valid = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    got = rdata;
    got_e = rsp_err;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    chk("after_hs_rsp_valid", 32'(rsp_valid), 0);
    chk("after_hs_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic rr, ww;
    int k;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) xact(1'b0, 1'b1, 3'd2, 32'(4 * i), $urandom, 0, g, ge);
    xact(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, g, ge);
    chk("sw10_err", 32'(ge), 0);
    chk("sw10_rdata", g, 0);
    xact(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 0, g, ge);
    chk("lw10", g, 32'hDEADBEEF);
    chk("lw10_err", 32'(ge), 0);
    xact(1'b0, 1'b1, 3'd0, 32'h11, 32'h80, 0, g, ge);
    xact(1'b1, 1'b0, 3'd0, 32'h11, 32'h0, 0, g, ge);
    chk("lb11", g, 32'hFFFFFF80);
    xact(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, 0, g, ge);
    chk("lbu11", g, 32'h00000080);
    xact(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 0, g, ge);
    chk("lw10_after_sb", g, 32'hDEAD80EF);
    xact(1'b1, 1'b0, 3'd1, 32'h13, 32'h0, 0, g, ge);
    chk("lh13_err", 32'(ge), 1);
    chk("lh13_rdata", g, 0);
    xact(1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 0, g, ge);
    chk("sw400_err", 32'(ge), 1);
    xact(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 0, g, ge);
    xact(1'b1, 1'b1, 3'd2, 32'h10, 32'h0, 0, g, ge);
    chk("rw_both_err", 32'(ge), 1);
    xact(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, 5, g, ge);
    chk("lhu12_hold", g, 32'h0000DEAD);
    xact(1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678, 0, g, ge);
    xact(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 0, g, ge);
    chk("lw20", g, 32'h12345678);
    issue(1'b0, 1'b1, 3'd2, 32'h20, 32'hFFFFFFFF, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_busy");
    req_valid = 1'b0;
    @(posedge clk);
    #1 chk_reset_outputs("rst_busy_edge");
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 0, g, ge);
    chk("lw20_after_rst", g, 32'h12345678);
    issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("resp_before_rst", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 15);
      rr = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'(k[0]);
      ww = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : ~rr;
      k = $urandom_range(0, 3);
      ra = (k == 0) ? $urandom : (k == 1) ? 32'(1016 + $urandom_range(0, 15)) : 32'($urandom_range(0, 1023));
      xact(rr, ww, 3'($urandom), ra, $urandom, $urandom_range(0, 3), g, ge);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of internal storage (byte range 0 to 4*DEPTH_WORDS-1).
REQ-002 SHALL have ports: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: req_valid  input  1  request present.
REQ-005 SHALL have ports: req_ready  output  1  block can accept a request.
REQ-006 SHALL have ports: mem_read  input  1  load request, as produced by the decode control unit.
REQ-007 SHALL have ports: mem_write  input  1  store request, as produced by the decode control unit.
REQ-008 SHALL have ports: funct3  input  3  access size/sign (0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu).
REQ-009 SHALL have ports: addr  input  32  byte address.
REQ-010 SHALL have ports: wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have ports: rsp_valid  output  1  response present.
REQ-012 SHALL have ports: rsp_ready  input  1  consumer takes the response.
REQ-013 SHALL have ports: rdata  output  32  load result, extended to 32 bits.
REQ-014 SHALL have ports: rsp_err  output  1  request was rejected; no side effect.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-016 IDLE: req_ready=1, rsp_valid=0; req_valid=1 at a rising edge captures mem_read, mem_write, funct3, addr and wdata, then moves to BUSY.
REQ-017 BUSY lasts exactly one cycle: req_ready=0; the storage access is performed and rdata/rsp_err are registered at the closing edge; next state RESP.
REQ-018 RESP: rsp_valid=1; rdata and rsp_err held stable until rsp_ready=1 at a rising edge, then IDLE.
REQ-019 Minimum latency is 2 cycles from the accepting edge to rsp_valid=1; one transaction in flight at a time.
REQ-020 req_ready SHALL be 0 in BUSY and RESP; inputs are ignored outside IDLE.
REQ-021 Error conditions, checked on captured values: mem_read==mem_write (both or neither).
REQ-022 Error conditions: read funct3 in {3,6,7}, or write funct3 > 2.
REQ-023 Error conditions: misalignment, i.e. halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-024 Error conditions: addr >= 4*DEPTH_WORDS (full 32-bit compare, no wrap).
REQ-025 On error: rsp_err=1, rdata=0, storage unchanged.
REQ-026 Word index is addr[31:2]; byte lane is addr[1:0]; halfword lane is addr[1].
REQ-027 Loads: lb/lh sign-extend the selected lane; lbu/lhu zero-extend; lw returns the full word.
REQ-028 Stores: sb writes only lane addr[1:0] with wdata[7:0]; sh writes lane addr[1] with wdata[15:0]; sw writes all four bytes; other bytes unchanged.
REQ-029 Successful store responses SHALL have rsp_err=0 and rdata=0.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, and clear all captured request registers.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 A store in BUSY commits only at a rising edge with rst_n=1; reset asserted during BUSY discards the pending store.
REQ-033 Reset asserted in RESP drops the response without handshake.

Verification
REQ-034 SHALL cover: sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10 -> rsp_err=0, rdata=0xDEADBEEF, rsp_valid at the 2nd cycle after the accepting edge.
REQ-035 SHALL cover: after REQ-034, sb addr=0x11 wdata=0x80, then lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0xDEAD80EF.
REQ-036 SHALL cover: lh addr=0x13 -> rsp_err=1, rdata=0; sw addr=0x400 (DEPTH_WORDS=256) -> rsp_err=1, memory unchanged; mem_read=mem_write=1 -> rsp_err=1.
REQ-037 SHALL cover: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata, rsp_err stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: sw 0x20=0x12345678; sw 0x20=0xFFFFFFFF with rst_n pulsed low during BUSY; then lw 0x20 -> 0x12345678, and all outputs at reset values during reset.
